// File: rtl/hum_pkg.sv
// Shared types and defaults for the humidity channel control sequencer.
package hum_pkg;

  localparam int unsigned HUM_SAMPLE_W = 8;
  localparam int unsigned HUM_HYST_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERIOD,
    REQ,
    WAIT_SAMPLE,
    EVAL
  } hum_state_e;

endpackage

// File: rtl/hum_hyst_eval.sv
// Combinational threshold/hysteresis decision for one humidity sample.
module hum_hyst_eval #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned HYST     = 2
) (
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [SAMPLE_W-1:0] i_low_thr,
  input  logic [SAMPLE_W-1:0] i_high_thr,
  input  logic                i_hum_on,
  input  logic                i_dehum_on,
  output logic                o_hum_on,
  output logic                o_dehum_on,
  output logic                o_bad_thr
);

  logic [SAMPLE_W:0] w_low_plus;
  logic [SAMPLE_W:0] w_low_lim;
  logic [SAMPLE_W:0] w_high_lim;
  logic [SAMPLE_W:0] w_s;
  logic [SAMPLE_W:0] w_hyst;

  assign w_s        = {1'b0, i_sample};
  assign w_hyst     = (SAMPLE_W+1)'(HYST);
  assign w_low_plus = {1'b0, i_low_thr} + w_hyst;

  // Release points saturate at the sample range limits.
  assign w_low_lim  = w_low_plus[SAMPLE_W] ? {1'b0, {SAMPLE_W{1'b1}}} : w_low_plus;
  assign w_high_lim = ({1'b0, i_high_thr} < w_hyst) ? '0 : ({1'b0, i_high_thr} - w_hyst);

  always_comb begin
    o_bad_thr  = 1'b0;
    o_hum_on   = 1'b0;
    o_dehum_on = 1'b0;
    if (i_low_thr >= i_high_thr) begin
      o_bad_thr = 1'b1;
    end else if (i_sample < i_low_thr) begin
      o_hum_on = 1'b1;
    end else if (i_sample > i_high_thr) begin
      o_dehum_on = 1'b1;
    end else begin
      o_hum_on   = i_hum_on && !(w_s >= w_low_lim);
      o_dehum_on = i_dehum_on && !(w_s <= w_high_lim);
    end
  end

endmodule

// File: rtl/hum_ctrl_fsm.sv
// Humidity channel sequencer: schedules sample requests off the 1 s tick,
// applies hysteresis to each sample and drives humidifier/dehumidifier.
module hum_ctrl_fsm
  import hum_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = HUM_SAMPLE_W,
  parameter int unsigned SEC_W     = 8,
  parameter int unsigned HYST      = HUM_HYST_DEF,
  parameter int unsigned TIMEOUT_S = 3
) (
  input  logic                i_pclk,
  input  logic                i_presetn,
  input  logic                i_hum_en,
  input  logic [SEC_W-1:0]    i_sample_period,
  input  logic [SAMPLE_W-1:0] i_hum_low_thr,
  input  logic [SAMPLE_W-1:0] i_hum_high_thr,
  input  logic [SAMPLE_W-1:0] i_hum_sample,
  input  logic                i_hum_sample_valid,
  input  logic                i_count_eq_1s,
  output logic                o_hum_counter_en,
  output logic                o_hum_counter_clr,
  output logic                o_hum_sample_req,
  output logic                o_humidifier_on,
  output logic                o_dehumidifier_on,
  output logic [SAMPLE_W-1:0] o_hum_last,
  output logic                o_hum_err
);

  hum_state_e          r_state;
  logic [SEC_W-1:0]    r_sec_cnt;
  logic                r_clr;
  logic                r_req;
  logic                r_hum_on;
  logic                r_dehum_on;
  logic                r_err;
  logic [SAMPLE_W-1:0] r_last;
  logic [SAMPLE_W-1:0] r_low_thr;
  logic [SAMPLE_W-1:0] r_high_thr;

  logic [SEC_W:0]      w_sec_inc;
  logic [SEC_W:0]      w_period;
  logic                w_eval_hum;
  logic                w_eval_dehum;
  logic                w_eval_bad;

  assign w_sec_inc = {1'b0, r_sec_cnt} + 1'b1;
  assign w_period  = (i_sample_period == '0) ? (SEC_W+1)'(1) : {1'b0, i_sample_period};

  hum_hyst_eval #(
    .SAMPLE_W (SAMPLE_W),
    .HYST     (HYST)
  ) u_eval (
    .i_sample   (r_last),
    .i_low_thr  (r_low_thr),
    .i_high_thr (r_high_thr),
    .i_hum_on   (r_hum_on),
    .i_dehum_on (r_dehum_on),
    .o_hum_on   (w_eval_hum),
    .o_dehum_on (w_eval_dehum),
    .o_bad_thr  (w_eval_bad)
  );

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state    <= IDLE;
      r_sec_cnt  <= '0;
      r_clr      <= 1'b0;
      r_req      <= 1'b0;
      r_hum_on   <= 1'b0;
      r_dehum_on <= 1'b0;
      r_err      <= 1'b0;
      r_last     <= '0;
      r_low_thr  <= '0;
      r_high_thr <= '0;
    end else begin
      r_clr <= 1'b0;
      r_req <= 1'b0;
      if (!i_hum_en) begin
        r_state    <= IDLE;
        r_sec_cnt  <= '0;
        r_hum_on   <= 1'b0;
        r_dehum_on <= 1'b0;
        r_err      <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state   <= WAIT_PERIOD;
            r_clr     <= 1'b1;
            r_sec_cnt <= '0;
          end
          WAIT_PERIOD: begin
            if (i_count_eq_1s) begin
              if (w_sec_inc >= w_period) begin
                r_state <= REQ;
                r_req   <= 1'b1;
              end else begin
                r_sec_cnt <= r_sec_cnt + 1'b1;
              end
            end
          end
          REQ: begin
            r_state   <= WAIT_SAMPLE;
            r_clr     <= 1'b1;
            r_sec_cnt <= '0;
          end
          WAIT_SAMPLE: begin
            // A valid sample beats a coincident timeout tick.
            if (i_hum_sample_valid) begin
              r_state    <= EVAL;
              r_last     <= i_hum_sample;
              r_low_thr  <= i_hum_low_thr;
              r_high_thr <= i_hum_high_thr;
            end else if (i_count_eq_1s) begin
              if (w_sec_inc >= (SEC_W+1)'(TIMEOUT_S)) begin
                r_state    <= WAIT_PERIOD;
                r_clr      <= 1'b1;
                r_sec_cnt  <= '0;
                r_err      <= 1'b1;
                r_hum_on   <= 1'b0;
                r_dehum_on <= 1'b0;
              end else begin
                r_sec_cnt <= r_sec_cnt + 1'b1;
              end
            end
          end
          EVAL: begin
            r_state    <= WAIT_PERIOD;
            r_clr      <= 1'b1;
            r_sec_cnt  <= '0;
            r_hum_on   <= w_eval_hum;
            r_dehum_on <= w_eval_dehum;
            if (w_eval_bad) r_err <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_hum_counter_en  = (r_state == WAIT_PERIOD) || (r_state == WAIT_SAMPLE);
  assign o_hum_counter_clr = r_clr | i_count_eq_1s;
  assign o_hum_sample_req  = r_req;
  assign o_humidifier_on   = r_hum_on;
  assign o_dehumidifier_on = r_dehum_on;
  assign o_hum_last        = r_last;
  assign o_hum_err         = r_err;

endmodule

// File: tb/tb_hum_ctrl_fsm.sv
// Self-checking bench for hum_ctrl_fsm; tick driven directly, scoreboard on evaluated samples.
module tb_hum_ctrl_fsm;

  logic       clk = 1'b0;
  logic       presetn = 1'b0;
  logic       hum_en = 1'b0;
  logic [7:0] sample_period = 8'd3;
  logic [7:0] low_thr = 8'd40;
  logic [7:0] high_thr = 8'd60;
  logic [7:0] sample = 8'd0;
  logic       sample_valid = 1'b0;
  logic       tick = 1'b0;
  logic       cnt_en, cnt_clr, req, hum_on, dehum_on, err;
  logic [7:0] last;

  typedef struct packed {
    logic       h;
    logic       d;
    logic       e;
    logic [7:0] s;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  hum_ctrl_fsm dut (
    .i_pclk             (clk),
    .i_presetn          (presetn),
    .i_hum_en           (hum_en),
    .i_sample_period    (sample_period),
    .i_hum_low_thr      (low_thr),
    .i_hum_high_thr     (high_thr),
    .i_hum_sample       (sample),
    .i_hum_sample_valid (sample_valid),
    .i_count_eq_1s      (tick),
    .o_hum_counter_en   (cnt_en),
    .o_hum_counter_clr  (cnt_clr),
    .o_hum_sample_req   (req),
    .o_humidifier_on    (hum_on),
    .o_dehumidifier_on  (dehum_on),
    .o_hum_last         (last),
    .o_hum_err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // From WAIT_PERIOD: tick until the request strobe, then move into WAIT_SAMPLE.
  task automatic request_cycle(output int n_ticks);
    n_ticks = 0;
    for (int i = 0; i < 20; i++) begin
      pulse_tick();
      n_ticks++;
      if (req) break;
    end
    if (!req) check("req_seen", 32'(req), 32'd1);
    step();
  endtask

  task automatic send_sample(input logic [7:0] s, input logic eh, input logic ed, input logic ee);
    int nt;
    request_cycle(nt);
    q_exp.push_back('{h: eh, d: ed, e: ee, s: s});
    sample = s;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    check_eval();
  endtask

  task automatic check_eval();
    exp_t e;
    e = q_exp.pop_front();
    check("hum_on", 32'(hum_on), 32'(e.h));
    check("dehum_on", 32'(dehum_on), 32'(e.d));
    check("err", 32'(err), 32'(e.e));
    check("last", 32'(last), 32'(e.s));
    check("never_both", 32'(hum_on & dehum_on), 32'd0);
  endtask

  initial begin
    int nt;
    #3;
    check("rst_outs", {25'd0, cnt_en, cnt_clr, req, hum_on, dehum_on, err, 1'b0},
          32'd0);
    check("rst_last", 32'(last), 32'd0);
    presetn = 1'b1;
    hum_en = 1'b1;
    step();
    check("entry_clr", 32'(cnt_clr), 32'd1);
    check("entry_en", 32'(cnt_en), 32'd1);
    step();
    check("clr_pulse_end", 32'(cnt_clr), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick = 1'b1;
      #1;
      check("tick_clr", 32'(cnt_clr), 32'd1);
      step();
      tick = 1'b0;
      check("req_timing", 32'(req), (i == 3) ? 32'd1 : 32'd0);
    end
    step();
    check("req_one_cycle", 32'(req), 32'd0);
    check("ws_entry_clr", 32'(cnt_clr), 32'd1);
    // Back to WAIT_PERIOD via a sample, and a stray valid there is ignored.
    q_exp.push_back('{h: 1'b1, d: 1'b0, e: 1'b0, s: 8'd35});
    sample = 8'd35;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    check_eval();
    sample = 8'd99;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("ignore_valid_wp", 32'(last), 32'd35);

    send_sample(8'd41, 1'b1, 1'b0, 1'b0);
    send_sample(8'd42, 1'b0, 1'b0, 1'b0);
    send_sample(8'd65, 1'b0, 1'b1, 1'b0);
    send_sample(8'd59, 1'b0, 1'b1, 1'b0);
    send_sample(8'd58, 1'b0, 1'b0, 1'b0);
    send_sample(8'd61, 1'b0, 1'b1, 1'b0);
    send_sample(8'd40, 1'b0, 1'b0, 1'b0);
    send_sample(8'd39, 1'b1, 1'b0, 1'b0);

    // Timeout with humidifier on.
    request_cycle(nt);
    pulse_tick();
    pulse_tick();
    check("to_not_yet", 32'(err), 32'd0);
    pulse_tick();
    check("to_err", 32'(err), 32'd1);
    check("to_drives", {30'd0, hum_on, dehum_on}, 32'd0);
    request_cycle(nt);
    check("period_after_to", 32'(nt), 32'd3);
    pulse_tick();
    pulse_tick();
    q_exp.push_back('{h: 1'b1, d: 1'b0, e: 1'b1, s: 8'd30});
    sample = 8'd30;
    sample_valid = 1'b1;
    tick = 1'b1;
    step();
    sample_valid = 1'b0;
    tick = 1'b0;
    step();
    check_eval();
    hum_en = 1'b0;
    step();
    check("en_off_err", 32'(err), 32'd0);
    check("en_off_drv", {30'd0, hum_on, dehum_on}, 32'd0);
    check("en_off_cnt", 32'(cnt_en), 32'd0);
    hum_en = 1'b1;
    step();

    // Bad thresholds, changed only before the next EVAL.
    low_thr = 8'd60;
    high_thr = 8'd40;
    send_sample(8'd20, 1'b0, 1'b0, 1'b1);
    low_thr = 8'd40;
    high_thr = 8'd60;
    send_sample(8'd50, 1'b0, 1'b0, 1'b1);
    hum_en = 1'b0;
    step();
    hum_en = 1'b1;
    step();
    send_sample(8'd10, 1'b1, 1'b0, 1'b0);

    // Async reset while waiting for a sample with humidifier on.
    request_cycle(nt);
    #2;
    presetn = 1'b0;
    #1;
    check("arst_hum", 32'(hum_on), 32'd0);
    check("arst_last", 32'(last), 32'd0);
    check("arst_en", 32'(cnt_en), 32'd0);
    step();
    presetn = 1'b1;
    step();
    check("restart_clr", 32'(cnt_clr), 32'd1);
    request_cycle(nt);
    check("restart_period", 32'(nt), 32'd3);
    sample = 8'd50;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();

    sample_period = 8'd0;
    request_cycle(nt);
    check("period_zero", 32'(nt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hum_ctrl_fsm.md
Name: hum_ctrl_fsm

Overview:
Control sequencer for the humidity channel.
- Sits directly upstream of the humidity 1 s timer counter: drives its enable/clear and consumes its count_eq_1s tick.
- Counts ticks to schedule periodic sensor sample requests and applies hysteresis thresholds to each returned sample.
- Drives the humidifier/dehumidifier outputs and reports status and errors to the register block.

Parameters:
SAMPLE_W, 8, width of humidity sample and thresholds (%RH, integer)
SEC_W, 8, width of the sample-period seconds counter
HYST, 2, hysteresis band in sample LSBs
TIMEOUT_S, 3, seconds allowed between sample request and sample valid

Ports:
pclk  input  1  system clock
presetn  input  1  asynchronous active-low reset
hum_en  input  1  channel enable from register block
sample_period  input  SEC_W  seconds between samples; 0 treated as 1
hum_low_thr  input  SAMPLE_W  humidify below this value
hum_high_thr  input  SAMPLE_W  dehumidify above this value
hum_sample  input  SAMPLE_W  sensor reading
hum_sample_valid  input  1  one-cycle strobe qualifying hum_sample
count_eq_1s  input  1  one-second tick from timer counter
hum_counter_en  output  1  timer counter enable
hum_counter_clr  output  1  timer counter synchronous clear
hum_sample_req  output  1  one-cycle sample request strobe
humidifier_on  output  1  humidifier drive
dehumidifier_on  output  1  dehumidifier drive
hum_last  output  SAMPLE_W  last accepted sample
hum_err  output  1  sticky sample-timeout / bad-threshold flag

Behaviour:
Reset and tick handling:
- Reset (async, presetn low): state IDLE; all outputs 0; hum_last 0; sec_cnt 0.
- hum_counter_clr = clr_q OR count_eq_1s (combinational). Clear has priority in the counter, so each tick spans exactly 100,000,000 pclk cycles.
- clr_q is a registered one-cycle pulse issued on every entry to WAIT_PERIOD or WAIT_SAMPLE.
- hum_counter_en = 1 in WAIT_PERIOD and WAIT_SAMPLE only.

States:
- IDLE: outputs off. hum_en=1 -> WAIT_PERIOD, clr_q=1, sec_cnt=0.
- WAIT_PERIOD: each count_eq_1s increments sec_cnt. When sec_cnt+1 >= max(sample_period,1) on a tick -> REQ.
- REQ: hum_sample_req=1 for exactly this cycle; sec_cnt=0 -> WAIT_SAMPLE (clr_q=1).
- WAIT_SAMPLE:
  - hum_sample_valid -> latch hum_last -> EVAL.
  - On the TIMEOUT_S-th tick without valid: hum_err=1, both drives 0 -> WAIT_PERIOD.
- EVAL (1 cycle), using registered thresholds and 9-bit arithmetic:
  - hum_low_thr >= hum_high_thr: hum_err=1, both drives 0.
  - s < low: humidifier_on=1, dehumidifier_on=0.
  - s > high: dehumidifier_on=1, humidifier_on=0.
  - Otherwise: humidifier_on clears if s >= low+HYST (saturate at max); dehumidifier_on clears if s <= high-HYST (floor 0); else hold.
  - Invariant: never both drives set.
  - Then -> WAIT_PERIOD.

Boundary and control rules:
- hum_en=0 in any state: next cycle -> IDLE, drives 0, hum_err cleared. hum_err is otherwise sticky.
- A valid arriving in REQ or WAIT_PERIOD is ignored.
- Valid and timeout tick in the same cycle: valid wins.
- Threshold changes take effect at the next EVAL only.
- sample_period changed mid-wait: compared on each tick against the current value; if already exceeded, REQ fires on the next tick.

Decomposition:
- Package hum_pkg: state enum typedef hum_state_e {IDLE, WAIT_PERIOD, REQ, WAIT_SAMPLE, EVAL}; constants HUM_SAMPLE_W, HUM_HYST_DEF.
- Optional sub-module hum_hyst_eval: combinational threshold/hysteresis decision, unit-tested alone.
- The FSM, seconds counter and output registers stay in hum_ctrl_fsm.

Test Plan:
- Bench drives count_eq_1s directly. hum_en=1, sample_period=3: hum_sample_req pulses once, in the cycle after the 3rd tick. hum_counter_clr is seen at entry and on each tick.
- low=40, high=60, sample=35 -> humidifier_on=1. Next sample 41 -> still 1. Next sample 42 -> 0.
- low=40, high=60, sample=65 -> dehumidifier_on=1. Next sample 58 -> 0. humidifier_on stays 0 throughout.
- No valid after request, TIMEOUT_S=3 -> on 3rd tick hum_err=1, drives 0, next request after the period. hum_en toggled 0 -> hum_err cleared.
- low=60, high=40, any sample -> hum_err=1, both drives 0.
- presetn asserted during WAIT_SAMPLE with humidifier_on=1 -> all outputs 0 immediately. After release, hum_en=1 restarts from IDLE with sec_cnt 0.
